acc_sequencer: RTL and testbench

Multi-cycle control sequencer for the 8-bit accumulator datapath. It fetches 9-bit instructions over an instruction-memory handshake, decodes the 3-bit mode field, and drives the register file's `wen`, `AccControl`, `ra1` and `ra2` controls. It sequences data-memory accesses for load/store and owns the PC and the EQ flag used by conditional jumps. It sits between the instruction/data memories and the regfile/ALU datapath.

---
 rtl/acc_seq_pkg.sv | 40 ++++
 rtl/acc_seq_decode.sv | 33 +++
 rtl/acc_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_acc_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_seq_pkg
// Description : Shared types and constants for the accumulator sequencer.
//               Provides the FSM state type, the 3-bit instruction modes
//               and the bit positions of the fields in the 9-bit IR.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_seq_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALTED = 3'd6
    } state_t;

    // Instruction modes (ir[8:6])
    localparam logic [2:0] MODE_HALT  = 3'b000;
    localparam logic [2:0] MODE_ALU   = 3'b001;
    localparam logic [2:0] MODE_UNARY = 3'b010;
    localparam logic [2:0] MODE_EQ    = 3'b011;
    localparam logic [2:0] MODE_JMP   = 3'b100;
    localparam logic [2:0] MODE_ST    = 3'b101;
    localparam logic [2:0] MODE_LD    = 3'b110;
    localparam logic [2:0] MODE_LWR   = 3'b111;

    // IR layout: mode = ir[8:6], fa = ir[5:3], fb = ir[2:0]
    localparam int IR_W        = 9;
    localparam int FIELD_W     = 3;
    localparam int IR_MODE_LSB = 6;
    localparam int IR_FA_LSB   = 3;
    localparam int IR_FB_LSB   = 0;

endpackage
`default_nettype wire

// File: rtl/acc_seq_decode.sv
`default_nettype none
// ============================================================================
// Module      : acc_seq_decode
// Description : Combinational instruction decoder. Maps the mode field of the
//               instruction register to the state following DECODE and to a
//               one-hot mode vector used by the sequencer.
// Ports       : i_mode       - mode field of the IR
//               o_next_state - state to enter after DECODE
//               o_mode_oh    - one-hot of i_mode (bit n set for mode n)
// Revision    : 1.0 - initial release
// ============================================================================
module acc_seq_decode
    import acc_seq_pkg::*;
(
    input  logic [FIELD_W-1:0] i_mode,
    output state_t             o_next_state,
    output logic [7:0]         o_mode_oh
);

    always_comb begin
        o_mode_oh    = 8'b0000_0001 << i_mode;
        o_next_state = ST_IDLE;
        case (i_mode)
            MODE_HALT:                               o_next_state = ST_HALTED;
            MODE_ALU, MODE_UNARY, MODE_EQ, MODE_JMP: o_next_state = ST_EXEC;
            MODE_ST, MODE_LD:                        o_next_state = ST_MEM;
            MODE_LWR:                                o_next_state = ST_WB;
            default:                                 o_next_state = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : acc_sequencer
// Description : Multi-cycle control sequencer for the 8-bit accumulator
//               datapath. Fetches 9-bit instructions, decodes them, sequences
//               data-memory accesses and drives the regfile/ALU controls.
//               Owns the PC, the EQ flag and a saturating retire counter.
// Ports       : clk, reset            - clock, async active-high reset
//               start                 - begin execution at PC 0 (idle/halted)
//               imem_req/addr/ack/rdata - instruction fetch handshake
//               dmem_req/we/ack       - data access handshake
//               alu_zero              - ALU zero flag, sampled by EQ
//               jmp_target            - jump destination from the datapath
//               wen/acc_ctl/ra1/ra2   - regfile controls
//               busy/halted           - status
//               retired               - saturating retired-instruction count
// Revision    : 1.0 - initial release
// ============================================================================
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [IR_W-1:0]  imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             alu_zero,
    input  logic [PC_W-1:0]  jmp_target,
    output logic             wen,
    output logic [2:0]       acc_ctl,
    output logic [2:0]       ra1,
    output logic [2:0]       ra2,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [PC_W-1:0]  c_PC_ONE  = PC_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    state_t             r_state;
    state_t             w_next_state;
    state_t             w_dec_next;
    logic [PC_W-1:0]    r_pc;
    logic [IR_W-1:0]    r_ir;
    logic               r_eq;
    logic [CNT_W-1:0]   r_retired;

    logic [FIELD_W-1:0] w_mode;
    logic [FIELD_W-1:0] w_fa;
    logic [FIELD_W-1:0] w_fb;
    logic [7:0]         w_mode_oh;
    logic               w_start_ok;
    logic               w_jmp_taken;
    logic               w_retire;
    logic               w_wb_mode;

    assign w_mode = r_ir[IR_MODE_LSB +: FIELD_W];
    assign w_fa   = r_ir[IR_FA_LSB   +: FIELD_W];
    assign w_fb   = r_ir[IR_FB_LSB   +: FIELD_W];

    acc_seq_decode u_decode (
        .i_mode       (w_mode),
        .o_next_state (w_dec_next),
        .o_mode_oh    (w_mode_oh)
    );

    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_HALTED));
    assign w_jmp_taken = (r_state == ST_EXEC) && w_mode_oh[MODE_JMP] && r_eq;
    // Modes that finish with a register-file write
    assign w_wb_mode   = w_mode_oh[MODE_ALU] | w_mode_oh[MODE_UNARY] |
                         w_mode_oh[MODE_LD]  | w_mode_oh[MODE_LWR];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (start) w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                w_next_state = w_dec_next;
            end
            ST_EXEC: begin
                // Only ALU/UNARY continue to write-back; EQ and JMP retire here
                w_next_state = (w_mode_oh[MODE_ALU] | w_mode_oh[MODE_UNARY]) ? ST_WB : ST_FETCH;
            end
            ST_MEM: begin
                if (dmem_ack) w_next_state = w_mode_oh[MODE_LD] ? ST_WB : ST_FETCH;
            end
            ST_WB: begin
                w_next_state = ST_FETCH;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: Moore outputs
    // ------------------------------------------------------------------------
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        wen      = 1'b0;
        acc_ctl  = 3'b000;
        ra1      = 3'b000;
        ra2      = 3'b000;
        busy     = 1'b1;
        halted   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_HALTED: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
            end
            ST_DECODE, ST_EXEC: begin
                acc_ctl = w_mode;
                ra1     = w_fa;
                ra2     = w_fb;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_mode_oh[MODE_ST];
                acc_ctl  = w_mode;
                ra1      = w_fa;
                ra2      = w_fb;
            end
            ST_WB: begin
                wen     = w_wb_mode;
                acc_ctl = w_mode;
                ra1     = w_fa;
                ra2     = w_fb;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Completion point of each instruction class
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            ST_DECODE: w_retire = w_mode_oh[MODE_HALT];
            ST_EXEC:   w_retire = w_mode_oh[MODE_EQ] | w_mode_oh[MODE_JMP];
            ST_MEM:    w_retire = dmem_ack & w_mode_oh[MODE_ST];
            ST_WB:     w_retire = 1'b1;
            default:   w_retire = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // PC, IR, EQ flag and retire counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_eq      <= 1'b0;
            r_retired <= '0;
        end else begin
            // start restarts from 0 but deliberately keeps EQ and the counter
            if (w_start_ok) begin
                r_pc <= '0;
            end else if ((r_state == ST_FETCH) && imem_ack) begin
                r_pc <= r_pc + c_PC_ONE;
                r_ir <= imem_rdata;
            end else if (w_jmp_taken) begin
                r_pc <= jmp_target;
            end

            // A taken jump consumes the flag
            if ((r_state == ST_EXEC) && w_mode_oh[MODE_EQ]) begin
                r_eq <= alu_zero;
            end else if (w_jmp_taken) begin
                r_eq <= 1'b0;
            end

            if (w_retire && (r_retired != c_CNT_MAX)) begin
                r_retired <= r_retired + c_CNT_ONE;
            end
        end
    end

    assign imem_addr = r_pc;
    assign retired   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_sequencer
// Description : Self-checking bench for acc_sequencer. An instruction-level
//               reference model (pc, eq flag, retire count, per-mode latency
//               and handshake expectations) is compared against the DUT while
//               randomized wait states, spurious acks and start pulses are
//               applied. A second instance with a 4-bit counter exercises
//               saturation of the retire count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       imem_ack;
    logic [8:0] imem_rdata;
    logic       dmem_ack;
    logic       alu_zero;
    logic [7:0] jmp_target;

    logic        imem_req, dmem_req, dmem_we, wen, busy, halted;
    logic [7:0]  imem_addr;
    logic [2:0]  acc_ctl, ra1, ra2;
    logic [15:0] retired;

    logic        imem_req_s, dmem_req_s, dmem_we_s, wen_s, busy_s, halted_s;
    logic [7:0]  imem_addr_s;
    logic [2:0]  acc_ctl_s, ra1_s, ra2_s;
    logic [3:0]  retired_s;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] m_pc;
    logic       m_eq;
    int         m_ret;
    int         m_ret_s;

    acc_sequencer #(.PC_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .alu_zero(alu_zero), .jmp_target(jmp_target),
        .wen(wen), .acc_ctl(acc_ctl), .ra1(ra1), .ra2(ra2),
        .busy(busy), .halted(halted), .retired(retired)
    );

    acc_sequencer #(.PC_W(8), .CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req_s), .imem_addr(imem_addr_s), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req_s), .dmem_we(dmem_we_s), .dmem_ack(dmem_ack),
        .alu_zero(alu_zero), .jmp_target(jmp_target),
        .wen(wen_s), .acc_ctl(acc_ctl_s), .ra1(ra1_s), .ra2(ra2_s),
        .busy(busy_s), .halted(halted_s), .retired(retired_s)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles from FETCH entry to the next FETCH entry (or to HALTED) with no waits
    function automatic int base_latency(input logic [2:0] mode);
        case (mode)
            3'b000:                 return 2;
            3'b001, 3'b010, 3'b110: return 4;
            default:                return 3;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 8'd0; m_eq = 1'b0; m_ret = 0; m_ret_s = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        imem_rdata = 9'd0; alu_zero = 1'b0; jmp_target = 8'd0;
        step();
        n_tests++;
        if ({imem_req, dmem_req, dmem_we, wen, acc_ctl, ra1, ra2, busy, halted, imem_addr, retired} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b dreq=%b wen=%b busy=%b addr=%h ret=%h, required all zero",
                     imem_req, dmem_req, wen, busy, imem_addr, retired);
        end
        step();
        reset = 1'b0;
        step(); step();
        n_tests++;
        if (busy !== 1'b0 || imem_req !== 1'b0 || retired_s !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_hold: got busy=%b req=%b ret_s=%0d, required 0 0 0", busy, imem_req, retired_s);
        end
        model_reset();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        m_pc = 8'd0;
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 8'd0 || busy !== 1'b1 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL start_fetch: got req=%b addr=%h busy=%b halted=%b, required 1 00 1 0",
                     imem_req, imem_addr, busy, halted);
        end
    endtask

    // Executes one instruction from FETCH entry; checks handshakes, controls,
    // latency and architectural state against the model.
    task automatic run_instr(input logic [8:0] instr, input int iwait, input int dwait,
                             input logic az, input logic [7:0] tgt);
        logic [2:0] mode;
        int  cyc, ireq_n, dreq_n, wen_n, icnt, dcnt, exp_cyc;
        logic fetched, we_seen, ctl_bad, is_mem, has_wen, is_halt;
        logic [8:0] wen_word;
        mode    = instr[8:6];
        is_mem  = (mode == 3'b101) || (mode == 3'b110);
        has_wen = (mode == 3'b001) || (mode == 3'b010) || (mode == 3'b110) || (mode == 3'b111);
        is_halt = (mode == 3'b000);
        exp_cyc = base_latency(mode) + iwait + (is_mem ? dwait : 0);
        cyc = 0; ireq_n = 0; dreq_n = 0; wen_n = 0; icnt = 0; dcnt = 0;
        fetched = 1'b0; we_seen = 1'b0; ctl_bad = 1'b0; wen_word = 9'd0;

        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            n_fail++;
            $display("FAIL fetch_entry[%b]: got req=%b addr=%h, required 1 %h", instr, imem_req, imem_addr, m_pc);
        end
        alu_zero   = az;
        jmp_target = tgt;
        forever begin
            start = ($urandom_range(0, 3) == 0);
            if (imem_req === 1'b1) begin
                ireq_n++;
                if (icnt == iwait) begin
                    imem_ack = 1'b1; imem_rdata = instr; fetched = 1'b1;
                end else begin
                    imem_ack = 1'b0; imem_rdata = 9'($urandom); icnt++;
                end
                if (acc_ctl !== 3'd0 || ra1 !== 3'd0 || ra2 !== 3'd0 || wen !== 1'b0) ctl_bad = 1'b1;
            end else begin
                imem_ack   = ($urandom_range(0, 3) == 0);
                imem_rdata = 9'($urandom);
            end
            if (dmem_req === 1'b1) begin
                dreq_n++;
                we_seen = dmem_we;
                if (dcnt == dwait) dmem_ack = 1'b1;
                else begin dmem_ack = 1'b0; dcnt++; end
            end else begin
                dmem_ack = ($urandom_range(0, 3) == 0);
            end
            if (wen === 1'b1) begin
                wen_n++;
                wen_word = {acc_ctl, ra1, ra2};
            end
            step();
            cyc++;
            if ((fetched && imem_req === 1'b1) || halted === 1'b1 || cyc > 60) break;
        end
        imem_ack = 1'b0; dmem_ack = 1'b0; start = 1'b0;

        // Architectural effect of the instruction
        m_pc = m_pc + 8'd1;
        if (mode == 3'b011) m_eq = az;
        else if (mode == 3'b100 && m_eq) begin m_pc = tgt; m_eq = 1'b0; end
        m_ret   = (m_ret   < 65535) ? m_ret + 1   : 65535;
        m_ret_s = (m_ret_s < 15)    ? m_ret_s + 1 : 15;

        n_tests++;
        if (cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL latency[%b]: got %0d cycles, required %0d", instr, cyc, exp_cyc);
        end
        n_tests++;
        if (ireq_n != iwait + 1 || ctl_bad) begin
            n_fail++;
            $display("FAIL fetch_req[%b]: got %0d req cycles ctl_bad=%b, required %0d and 0",
                     instr, ireq_n, ctl_bad, iwait + 1);
        end
        n_tests++;
        if (dreq_n != (is_mem ? dwait + 1 : 0) || (is_mem && we_seen !== (mode == 3'b101))) begin
            n_fail++;
            $display("FAIL dmem[%b]: got %0d req cycles we=%b, required %0d we=%b",
                     instr, dreq_n, we_seen, is_mem ? dwait + 1 : 0, mode == 3'b101);
        end
        n_tests++;
        if (wen_n != (has_wen ? 1 : 0) || (has_wen && wen_word !== instr)) begin
            n_fail++;
            $display("FAIL wen[%b]: got %0d cycles ctl/ra=%b, required %0d ctl/ra=%b",
                     instr, wen_n, wen_word, has_wen ? 1 : 0, instr);
        end
        n_tests++;
        if (imem_addr !== m_pc || halted !== is_halt || busy !== !is_halt) begin
            n_fail++;
            $display("FAIL state_after[%b]: got addr=%h halted=%b busy=%b, required %h %b %b",
                     instr, imem_addr, halted, busy, m_pc, is_halt, !is_halt);
        end
        n_tests++;
        if (retired !== 16'(m_ret) || retired_s !== 4'(m_ret_s) || imem_addr_s !== m_pc || halted_s !== is_halt) begin
            n_fail++;
            $display("FAIL retired[%b]: got %0d/%0d, required %0d/%0d",
                     instr, retired, retired_s, m_ret, m_ret_s);
        end
    endtask

    task automatic test_alu_op();
        run_instr(9'b001_000_011, 0, 0, 1'b0, 8'h00);
        n_tests++;
        if (imem_addr !== 8'd1 || retired !== 16'd1) begin
            n_fail++;
            $display("FAIL alu_first: got addr=%h ret=%0d, required 01 1", imem_addr, retired);
        end
    endtask

    task automatic test_eq_jmp();
        run_instr(9'b011_001_010, 0, 0, 1'b1, 8'h00);
        run_instr(9'b100_000_000, 0, 0, 1'b0, 8'h40);
        n_tests++;
        if (imem_addr !== 8'h40) begin
            n_fail++;
            $display("FAIL jmp_taken: got addr=%h, required 40", imem_addr);
        end
        run_instr(9'b000_111_111, 1, 0, 1'b0, 8'h00);
        do_start();
        run_instr(9'b011_001_010, 0, 0, 1'b0, 8'h00);
        run_instr(9'b100_000_000, 0, 0, 1'b1, 8'h40);
        n_tests++;
        if (imem_addr !== 8'h02) begin
            n_fail++;
            $display("FAIL jmp_not_taken: got addr=%h, required 02", imem_addr);
        end
    endtask

    task automatic test_mem();
        run_instr(9'b110_000_101, 0, 3, 1'b0, 8'h00);
        run_instr(9'b101_010_001, 0, 0, 1'b0, 8'h00);
        run_instr(9'b111_100_110, 2, 0, 1'b0, 8'h00);
        run_instr(9'b010_011_000, 3, 0, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        logic [8:0] instr;
        for (int i = 0; i < 40; i++) begin
            instr = {3'($urandom_range(1, 7)), 6'($urandom)};
            run_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_reset_mid_mem();
        logic bad;
        bad = 1'b0;
        imem_ack = 1'b1; imem_rdata = 9'b110_001_010;
        step();
        imem_ack = 1'b0;
        step();
        step();
        n_tests++;
        if (dmem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_mem_wait: got dmem_req=%b, required 1", dmem_req);
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (dmem_req !== 1'b0 || busy !== 1'b0 || imem_addr !== 8'd0 || wen !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got dreq=%b busy=%b addr=%h wen=%b, required 0 0 00 0",
                     dmem_req, busy, imem_addr, wen);
        end
        model_reset();
        dmem_ack = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy !== 1'b0 || dmem_req !== 1'b0 || wen !== 1'b0) bad = 1'b1;
        end
        dmem_ack = 1'b0;
        n_tests++;
        if (bad || retired !== 16'd0) begin
            n_fail++;
            $display("FAIL late_ack: got bad=%b ret=%0d, required 0 0", bad, retired);
        end
    endtask

    task automatic test_halt_wrap();
        do_start();
        run_instr(9'b011_000_000, 0, 0, 1'b1, 8'h00);
        run_instr(9'b100_000_000, 0, 0, 1'b0, 8'hFF);
        run_instr(9'b000_101_010, 0, 0, 1'b0, 8'h00);
        n_tests++;
        if (halted !== 1'b1 || imem_addr !== 8'h00 || retired !== 16'd3) begin
            n_fail++;
            $display("FAIL halt_wrap: got halted=%b addr=%h ret=%0d, required 1 00 3", halted, imem_addr, retired);
        end
        do_start();
        run_instr(9'b001_110_101, 0, 0, 1'b0, 8'h00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        do_start();
        test_alu_op();
        test_eq_jmp();
        test_mem();
        test_random();
        test_reset_mid_mem();
        test_halt_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
